// File: rtl/apb_master_bridge.sv
// ---------------------------------------------------------------------------
// apb_master_bridge
//
// Purpose
//   APB initiator that sits between the CPU data-bus port and the APB
//   peripheral slaves. It takes one CPU load/store at a time, maps the address
//   onto one of NUM_SLAVES equally sized regions, and runs the APB
//   SETUP/ACCESS sequence. When the transfer ends it returns the read data
//   together with a one-cycle done pulse. If the selected slave holds PREADY
//   low for too long, a wait-state timeout ends the transfer so the CPU does
//   not hang.
//
// Parameters
//   NUM_SLAVES     number of PSEL lines / slave regions
//   BASE_ADDR      first byte address of the APB region
//   SLV_SIZE_LOG2  log2 of the byte size of one slave region
//   TIMEOUT_CYC    maximum ACCESS cycles without PREADY (0 disables)
//
// Ports
//   PCLK        clock, all logic on the rising edge
//   PRESET      synchronous active-high reset
//   i_req       CPU request, only looked at while idle
//   i_we        1 = write, 0 = read
//   i_addr      byte address
//   i_wdata     write data
//   o_rdata     read data, valid while o_ready = 1 (zero otherwise)
//   o_ready     one-cycle transfer-complete pulse
//   o_err       qualifies o_ready: unmapped address or timeout
//   PADDR       APB address (full captured request address)
//   PWDATA      APB write data
//   PWRITE      APB direction
//   PENABLE     APB access phase
//   PSEL        one-hot slave select
//   PRDATA_ALL  slave k read data in bits [32k+31:32k]
//   PREADY_ALL  slave k ready in bit k
// ---------------------------------------------------------------------------
module apb_master_bridge #(
    parameter int          NUM_SLAVES    = 4,
    parameter logic [31:0] BASE_ADDR     = 32'h1000_0000,
    parameter int          SLV_SIZE_LOG2 = 12,
    parameter int          TIMEOUT_CYC   = 255
) (
    input  logic                       PCLK,
    input  logic                       PRESET,

    input  logic                       i_req,
    input  logic                       i_we,
    input  logic [31:0]                i_addr,
    input  logic [31:0]                i_wdata,
    output logic [31:0]                o_rdata,
    output logic                       o_ready,
    output logic                       o_err,

    output logic [31:0]                PADDR,
    output logic [31:0]                PWDATA,
    output logic                       PWRITE,
    output logic                       PENABLE,
    output logic [NUM_SLAVES-1:0]      PSEL,
    input  logic [32*NUM_SLAVES-1:0]   PRDATA_ALL,
    input  logic [NUM_SLAVES-1:0]      PREADY_ALL
);

    // The counter only ever has to hold values up to TIMEOUT_CYC-1.
    localparam int TO_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC + 1) : 1;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SETUP  = 2'd1;
    localparam logic [1:0] ST_ACCESS = 2'd2;

    logic [1:0]      state;
    logic [TO_W-1:0] to_cnt;

    logic                  req_hit;
    logic [NUM_SLAVES-1:0] req_sel;
    logic                  pready_sel;
    logic [31:0]           prdata_sel;
    logic                  to_expire;

    // -----------------------------------------------------------------------
    // Address decode helpers
    // -----------------------------------------------------------------------
    // The range check must happen before the subtraction is trusted: an
    // address below BASE_ADDR wraps to a huge offset, but it is rejected by
    // the first term anyway.
    function automatic logic decode_hit(input logic [31:0] addr);
        logic [31:0] off;
        logic [31:0] idx;
        off = addr - BASE_ADDR;
        idx = off >> SLV_SIZE_LOG2;
        return (addr >= BASE_ADDR) && (idx < 32'(NUM_SLAVES));
    endfunction

    // One-hot select for the region that holds addr; all-zero on a miss.
    function automatic logic [NUM_SLAVES-1:0] decode_sel(input logic [31:0] addr);
        logic [31:0]           off;
        logic [31:0]           idx;
        logic [NUM_SLAVES-1:0] sel;
        off = addr - BASE_ADDR;
        idx = off >> SLV_SIZE_LOG2;
        sel = '0;
        for (int k = 0; k < NUM_SLAVES; k++) begin
            if ((addr >= BASE_ADDR) && (idx == 32'(k))) begin
                sel[k] = 1'b1;
            end
        end
        return sel;
    endfunction

    always_comb begin
        req_hit = decode_hit(i_addr);
        req_sel = decode_sel(i_addr);
    end

    // -----------------------------------------------------------------------
    // Slave response mux
    // -----------------------------------------------------------------------
    // PSEL is held for the whole transfer, so it serves directly as the mux
    // select. Lines of unselected slaves never reach the state machine.
    always_comb begin
        pready_sel = 1'b0;
        prdata_sel = '0;
        for (int k = 0; k < NUM_SLAVES; k++) begin
            if (PSEL[k]) begin
                pready_sel = PREADY_ALL[k];
                prdata_sel = PRDATA_ALL[32*k +: 32];
            end
        end
    end

    // to_cnt counts the ACCESS cycles already spent without PREADY. The
    // current cycle is the TIMEOUT_CYC-th once to_cnt reaches TIMEOUT_CYC-1.
    // PREADY in that same cycle still takes priority.
    always_comb begin
        to_expire = (TIMEOUT_CYC != 0) &&
                    ((32'(to_cnt) + 32'd1) == 32'(TIMEOUT_CYC));
    end

    // -----------------------------------------------------------------------
    // Transfer state machine; every output is a register
    // -----------------------------------------------------------------------
    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            state   <= ST_IDLE;
            to_cnt  <= '0;
            o_rdata <= '0;
            o_ready <= 1'b0;
            o_err   <= 1'b0;
            PADDR   <= '0;
            PWDATA  <= '0;
            PWRITE  <= 1'b0;
            PENABLE <= 1'b0;
            PSEL    <= '0;
        end else begin
            // The done pulse and its data last exactly one cycle.
            o_ready <= 1'b0;
            o_err   <= 1'b0;
            o_rdata <= '0;

            case (state)
                ST_IDLE: begin
                    if (i_req) begin
                        if (req_hit) begin
                            // Request fields are captured here only. Later
                            // changes on i_addr/i_we/i_wdata have no effect.
                            PADDR   <= i_addr;
                            PWDATA  <= i_wdata;
                            PWRITE  <= i_we;
                            PSEL    <= req_sel;
                            PENABLE <= 1'b0;
                            state   <= ST_SETUP;
                        end else begin
                            // Unmapped: answer at once, the bus stays quiet.
                            o_ready <= 1'b1;
                            o_err   <= 1'b1;
                        end
                    end
                end

                ST_SETUP: begin
                    PENABLE <= 1'b1;
                    to_cnt  <= '0;
                    state   <= ST_ACCESS;
                end

                ST_ACCESS: begin
                    if (pready_sel) begin
                        o_ready <= 1'b1;
                        o_rdata <= PWRITE ? 32'd0 : prdata_sel;
                        PSEL    <= '0;
                        PENABLE <= 1'b0;
                        state   <= ST_IDLE;
                    end else if (to_expire) begin
                        o_ready <= 1'b1;
                        o_err   <= 1'b1;
                        PSEL    <= '0;
                        PENABLE <= 1'b0;
                        state   <= ST_IDLE;
                    end else begin
                        to_cnt <= to_cnt + 1'b1;
                    end
                end

                default: begin
                    // Unused encoding: drop the bus and return to idle.
                    PSEL    <= '0;
                    PENABLE <= 1'b0;
                    state   <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_apb_master_bridge.sv
// ---------------------------------------------------------------------------
// tb_apb_master_bridge
//
// Purpose
//   Drives CPU requests into apb_master_bridge and emulates four APB slaves,
//   each with a programmable number of wait states and a word memory. A
//   transaction-level reference model predicts every outcome and queues it.
//   The monitor pops those predictions and checks them against what the bus
//   and the CPU port actually show.
// ---------------------------------------------------------------------------
module tb_apb_master_bridge;

    localparam int          NS    = 4;
    localparam logic [31:0] BASE  = 32'h1000_0000;
    localparam int          TO    = 16;
    localparam int          NEVER = 1000;

    logic               PCLK;
    logic               PRESET;
    logic               i_req;
    logic               i_we;
    logic [31:0]        i_addr;
    logic [31:0]        i_wdata;
    logic [31:0]        o_rdata;
    logic               o_ready;
    logic               o_err;
    logic [31:0]        PADDR;
    logic [31:0]        PWDATA;
    logic               PWRITE;
    logic               PENABLE;
    logic [NS-1:0]      PSEL;
    logic [32*NS-1:0]   PRDATA_ALL;
    logic [NS-1:0]      PREADY_ALL;

    apb_master_bridge #(
        .NUM_SLAVES    (NS),
        .BASE_ADDR     (BASE),
        .SLV_SIZE_LOG2 (12),
        .TIMEOUT_CYC   (TO)
    ) dut (
        .PCLK       (PCLK),
        .PRESET     (PRESET),
        .i_req      (i_req),
        .i_we       (i_we),
        .i_addr     (i_addr),
        .i_wdata    (i_wdata),
        .o_rdata    (o_rdata),
        .o_ready    (o_ready),
        .o_err      (o_err),
        .PADDR      (PADDR),
        .PWDATA     (PWDATA),
        .PWRITE     (PWRITE),
        .PENABLE    (PENABLE),
        .PSEL       (PSEL),
        .PRDATA_ALL (PRDATA_ALL),
        .PREADY_ALL (PREADY_ALL)
    );

    initial PCLK = 1'b0;
    always #5 PCLK = ~PCLK;

    int cyc = 0;
    always @(posedge PCLK) cyc <= cyc + 1;

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish, got cycle %0d, required < 30000", cyc);
        $fatal(1);
    end

    // ---------------------------------------------------------------------
    // Bookkeeping
    // ---------------------------------------------------------------------
    int n_chk  = 0;
    int n_pass = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
        n_chk++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", name, act, req, cyc);
    endtask

    function automatic logic [127:0] all_outs();
        return {24'b0, o_rdata, o_ready, o_err, PADDR, PWDATA, PWRITE, PENABLE, PSEL};
    endfunction

    // Power-on contents of a slave word that was never written.
    function automatic logic [31:0] dflt(input logic [31:0] a);
        return {a[15:0], ~a[15:0]} ^ 32'h3C5A_0F0F;
    endfunction

    typedef struct {
        logic          we;
        logic [31:0]   addr;
        logic [31:0]   wdata;
        logic [31:0]   rdata;
        logic          err;
        logic [NS-1:0] psel;
        int            lat;   // cycles from drive of i_req to visible o_ready
        int            acc;   // number of cycles with PENABLE = 1
        int            t0;
    } exp_t;

    exp_t exp_q[$];
    logic [31:0] model_mem[logic [31:0]];
    int wait_cfg[NS];

    // ---------------------------------------------------------------------
    // Slave emulation: slave k raises PREADY after wait_cfg[k] extra ACCESS
    // cycles. Unselected slaves toggle random junk on their lines.
    // ---------------------------------------------------------------------
    logic [31:0] slave_mem[logic [31:0]];

    initial begin
        int acc[NS];
        for (int k = 0; k < NS; k++) acc[k] = 0;
        PREADY_ALL = '0;
        PRDATA_ALL = '0;
        forever begin
            @(negedge PCLK);
            for (int k = 0; k < NS; k++) begin
                if (PSEL[k] === 1'b1 && PENABLE === 1'b1) begin
                    PREADY_ALL[k] = (acc[k] == wait_cfg[k]);
                    PRDATA_ALL[32*k +: 32] = slave_mem.exists(PADDR) ? slave_mem[PADDR] : dflt(PADDR);
                    if (acc[k] == wait_cfg[k] && PWRITE === 1'b1) slave_mem[PADDR] = PWDATA;
                    acc[k]++;
                end else begin
                    acc[k] = 0;
                    PREADY_ALL[k] = 1'($urandom_range(0, 1));
                    PRDATA_ALL[32*k +: 32] = $urandom;
                end
            end
        end
    end

    // ---------------------------------------------------------------------
    // Reference model + driver: predict the outcome, queue it, drive i_req.
    // Call at a falling edge while the bridge is idle (or in its done cycle).
    // ---------------------------------------------------------------------
    task automatic issue(input logic we, input logic [31:0] addr, input logic [31:0] wdata, input int wt);
        exp_t   e;
        longint off;
        int     idx;
        e.we = we; e.addr = addr; e.wdata = wdata; e.t0 = cyc;
        e.psel = '0; e.rdata = '0; e.err = 1'b1; e.lat = 1; e.acc = 0;
        off = longint'(addr) - longint'(BASE);
        if (off >= 0 && off / 4096 < NS) begin
            idx = int'(off / 4096);
            e.psel[idx] = 1'b1;
            wait_cfg[idx] = wt;
            if (wt >= TO) begin
                e.lat = TO + 2;
                e.acc = TO;
            end else begin
                e.err = 1'b0;
                e.lat = wt + 3;
                e.acc = wt + 1;
                if (we) model_mem[addr] = wdata;
                else e.rdata = model_mem.exists(addr) ? model_mem[addr] : dflt(addr);
            end
        end
        exp_q.push_back(e);
        i_req = 1'b1; i_we = we; i_addr = addr; i_wdata = wdata;
    endtask

    // Waits for the done pulse. Right after acceptance, scramble the request
    // fields; drop i_req unless the caller chains another request.
    task automatic wait_done(input bit drop);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 60 && !seen; i++) begin
            @(negedge PCLK);
            if (i == 0) begin
                if (drop) i_req = 1'b0;
                i_we = 1'($urandom_range(0, 1));
                i_addr = $urandom;
                i_wdata = $urandom;
            end
            if (o_ready === 1'b1) seen = 1'b1;
        end
        if (!seen) begin
            n_chk++;
            $display("FAIL done_wait: o_ready got 0 for 60 cycles, required 1 (cycle %0d)", cyc);
        end
    endtask

    // ---------------------------------------------------------------------
    // Monitor / scoreboard
    // ---------------------------------------------------------------------
    initial begin
        int   en_cnt;
        exp_t e;
        en_cnt = 0;
        forever begin
            @(negedge PCLK);
            if (PRESET === 1'b1) begin
                en_cnt = 0;
                exp_q.delete();
            end else begin
                if (PENABLE === 1'b1) en_cnt++;
                if (PSEL !== '0 && PENABLE === 1'b0) begin
                    if (exp_q.size() == 0) begin
                        check("setup_unrequested", 128'(PSEL), 128'(0));
                    end else begin
                        e = exp_q[0];
                        check("setup_psel", 128'(PSEL), 128'(e.psel));
                        check("setup_paddr", 128'(PADDR), 128'(e.addr));
                        check("setup_pwrite", 128'(PWRITE), 128'(e.we));
                        if (e.we) check("setup_pwdata", 128'(PWDATA), 128'(e.wdata));
                    end
                end
                if (o_ready === 1'b1) begin
                    if (exp_q.size() == 0) begin
                        n_chk++;
                        $display("FAIL ready_unrequested: o_ready got 1, required 0 (cycle %0d)", cyc);
                    end else begin
                        e = exp_q.pop_front();
                        check("ready_err", 128'(o_err), 128'(e.err));
                        check("ready_rdata", 128'(o_rdata), 128'(e.rdata));
                        check("ready_latency", 128'(cyc - e.t0), 128'(e.lat));
                        check("access_cycles", 128'(en_cnt), 128'(e.acc));
                    end
                    en_cnt = 0;
                end
            end
        end
    end

    // ---------------------------------------------------------------------
    // Stimulus
    // ---------------------------------------------------------------------
    initial begin
        int          rc;
        bit          hold;
        logic        we;
        logic [31:0] addr;
        int          wt;
        int          r;

        PRESET = 1'b1; i_req = 1'b0; i_we = 1'b0; i_addr = '0; i_wdata = '0;
        for (int k = 0; k < NS; k++) wait_cfg[k] = 0;
        repeat (3) @(negedge PCLK);
        check("reset_outputs", all_outs(), 128'(0));
        PRESET = 1'b0;
        repeat (3) begin
            @(negedge PCLK);
            check("idle_psel", 128'(PSEL), 128'(0));
        end

        // Write 0xA5 to slave 2, one wait state.
        issue(1'b1, 32'h1000_2008, 32'h0000_00A5, 1); wait_done(1'b1);
        // Store 0x42, then zero-wait read of it from slave 1.
        issue(1'b1, 32'h1000_100C, 32'h0000_0042, 0); wait_done(1'b1);
        issue(1'b0, 32'h1000_100C, 32'h0, 0);         wait_done(1'b1);

        // Reset while idle with non-zero bus registers.
        @(negedge PCLK);
        PRESET = 1'b1;
        repeat (2) @(negedge PCLK);
        check("idle_reset_outputs", all_outs(), 128'(0));
        PRESET = 1'b0;
        @(negedge PCLK);
        check("post_reset_psel", 128'(PSEL), 128'(0));

        // Unmapped addresses: far above, just below, just past the region.
        issue(1'b0, 32'h2000_0000, 32'h0, 0);          wait_done(1'b1);
        issue(1'b0, 32'h0FFF_FFFC, 32'h0, 0);          wait_done(1'b1);
        issue(1'b1, 32'h1000_4000, 32'h1111_2222, 0);  wait_done(1'b1);

        // Dead slave 0, then a normal transfer to slave 1.
        issue(1'b0, 32'h1000_0010, 32'h0, NEVER);      wait_done(1'b1);
        issue(1'b0, 32'h1000_1000, 32'h0, 0);          wait_done(1'b1);

        // PREADY on the last allowed ACCESS cycle wins over the timeout.
        issue(1'b1, 32'h1000_0020, 32'hDEAD_BEEF, TO - 1); wait_done(1'b1);
        issue(1'b0, 32'h1000_0020, 32'h0, 2);              wait_done(1'b1);
        // One wait state more than allowed times out.
        issue(1'b1, 32'h1000_0024, 32'h5555_AAAA, TO);     wait_done(1'b1);

        // Back-to-back write then read on slave 3 with i_req held high.
        issue(1'b1, 32'h1000_3004, 32'h1234_5678, 0); wait_done(1'b0);
        issue(1'b0, 32'h1000_3004, 32'h0, 1);         wait_done(1'b1);

        // Reset in the middle of ACCESS.
        issue(1'b0, 32'h1000_0100, 32'h0, NEVER);
        @(negedge PCLK);
        i_req = 1'b0;
        repeat (3) @(negedge PCLK);
        check("abort_in_access", 128'(PENABLE), 128'(1));
        PRESET = 1'b1;
        @(negedge PCLK);
        check("abort_outputs", all_outs(), 128'(0));
        @(negedge PCLK);
        PRESET = 1'b0;
        rc = 0;
        repeat (25) begin
            @(negedge PCLK);
            if (o_ready === 1'b1) rc++;
        end
        check("abort_no_ready", 128'(rc), 128'(0));
        issue(1'b0, 32'h1000_0100, 32'h0, 0); wait_done(1'b1);

        // Randomized traffic.
        for (int n = 0; n < 80; n++) begin
            r = $urandom_range(0, 9);
            if (r == 0)      addr = $urandom & 32'h0FFF_FFFC;
            else if (r == 1) addr = 32'h1000_4000 + ($urandom & 32'h00FF_FFFC);
            else             addr = BASE + 32'($urandom_range(0, NS - 1)) * 32'd4096
                                        + 32'($urandom_range(0, 7)) * 32'd4;
            r = $urandom_range(0, 9);
            if (r == 0)      wt = NEVER;
            else if (r == 1) wt = TO - 1;
            else if (r == 2) wt = TO;
            else             wt = $urandom_range(0, 3);
            we = 1'($urandom_range(0, 1));
            hold = ($urandom_range(0, 2) == 0) && (n != 79);
            issue(we, addr, $urandom, wt);
            wait_done(!hold);
            if (!hold) repeat ($urandom_range(0, 2)) @(negedge PCLK);
        end

        repeat (5) @(negedge PCLK);
        check("queue_drained", 128'(exp_q.size()), 128'(0));
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
